// File: rtl/store_merge_unit_if.sv
// Store request and data-memory port bundle for store_merge_unit.
// The slave modport is the unit itself. The master modport is the pipeline or
// memory side that drives requests and read data.
interface store_merge_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_data;
    logic [1:0]            req_size;

    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;

    logic                  store_done;
    logic                  align_err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_rd_en, mem_addr, mem_we, mem_wdata, mem_be,
               store_done, align_err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_rd_en, mem_addr, mem_we, mem_wdata, mem_be,
               store_done, align_err
    );
endinterface

// File: rtl/store_merge_unit.sv
// Store merge unit. It accepts byte, half and word stores and turns each one
// into a single full-word memory write. A word store is written directly.
// A byte or half store reads the old word, waits MEM_LAT cycles, merges the
// new lanes into it and writes the result back. Misaligned or illegal
// requests are rejected with a one-cycle align_err pulse and never touch
// memory.
module store_merge_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    store_merge_unit_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_WR,
        S_ERR
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [OFF_W-1:0]    off_reg;
    logic                half_reg;
    logic [15:0]         data_reg;

    logic                ready_reg;
    logic                rd_en_reg;
    logic                we_reg;
    logic                done_reg;
    logic                err_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [NB-1:0]       be_reg;

    // Request decode: lane offset, word-aligned base and legality.
    logic [OFF_W-1:0]    req_off;
    logic [ADDR_W-1:0]   req_base;
    logic                req_legal;

    assign req_off  = bus.req_addr[OFF_W-1:0];
    assign req_base = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // A half must start on an even lane, a word on lane 0, size 3 is never legal.
    always_comb begin
        req_legal = 1'b0;
        case (bus.req_size)
            2'd0:    req_legal = 1'b1;
            2'd1:    req_legal = ~req_off[0];
            2'd2:    req_legal = (req_off == '0);
            default: req_legal = 1'b0;
        endcase
    end

    // Per-lane merge of the captured store data into the word read back.
    // Lane off takes the low byte; for a half, lane off+1 takes the high byte.
    logic [NB-1:0]       lane_sel;
    logic [DATA_W-1:0]   merged;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic lo_hit;
        logic hi_hit;
        assign lo_hit        = (off_reg == OFF_W'(gi));
        assign hi_hit        = half_reg && ((off_reg + OFF_W'(1)) == OFF_W'(gi));
        assign lane_sel[gi]  = lo_hit | hi_hit;
        assign merged[8*gi +: 8] = lo_hit ? data_reg[7:0] :
                                   hi_hit ? data_reg[15:8] :
                                   bus.mem_rdata[8*gi +: 8];
    end

    // Control FSM; every bus output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            off_reg   <= '0;
            half_reg  <= 1'b0;
            data_reg  <= '0;
            ready_reg <= 1'b1;
            rd_en_reg <= 1'b0;
            we_reg    <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        off_reg   <= req_off;
                        half_reg  <= (bus.req_size == 2'd1);
                        data_reg  <= bus.req_data[15:0];
                        ready_reg <= 1'b0;
                        if (!req_legal) begin
                            err_reg   <= 1'b1;
                            state_reg <= S_ERR;
                        end else if (bus.req_size == 2'd2) begin
                            addr_reg  <= req_base;
                            wdata_reg <= bus.req_data;
                            be_reg    <= '1;
                            we_reg    <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= S_WR;
                        end else begin
                            addr_reg  <= req_base;
                            rd_en_reg <= 1'b1;
                            state_reg <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    rd_en_reg <= 1'b0;
                    cnt_reg   <= CNT_W'(MEM_LAT - 1);
                    state_reg <= S_WT;
                end
                S_WT: begin
                    if (cnt_reg == '0) begin
                        wdata_reg <= merged;
                        be_reg    <= lane_sel;
                        we_reg    <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= S_WR;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                S_WR: begin
                    we_reg    <= 1'b0;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end
                S_ERR: begin
                    err_reg   <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    rd_en_reg <= 1'b0;
                    we_reg    <= 1'b0;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_reg;
    assign bus.mem_rd_en  = rd_en_reg;
    assign bus.mem_addr   = addr_reg;
    assign bus.mem_we     = we_reg;
    assign bus.mem_wdata  = wdata_reg;
    assign bus.mem_be     = be_reg;
    assign bus.store_done = done_reg;
    assign bus.align_err  = err_reg;
endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit. Two instances: 32-bit data with read latency 1,
// and 64-bit data with read latency 3. A byte-level reference memory gives the
// expected merged words. A separate latency-accurate memory model serves the
// DUT reads and takes its writes. Outside the valid read-data cycle the read
// bus carries random junk.
module tb_store_merge_unit;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_merge_unit_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
    store_merge_unit_if #(.DATA_W(64), .ADDR_W(32)) ifb ();

    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT_A)) dut_a (
        .clk(clk), .reset(rst), .bus(ifa.slave));
    store_merge_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(LAT_B)) dut_b (
        .clk(clk), .reset(rst), .bus(ifb.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- memories ----------------
    logic [7:0] dut_mem [longint];
    logic [7:0] ref_mem [longint];

    function automatic longint key(input int inst, input logic [31:0] a);
        return (longint'(inst) << 32) | longint'(a);
    endfunction

    function automatic logic [7:0] init_byte(input int inst, input logic [31:0] a);
        return 8'(a * 32'd37 + 32'(inst) * 32'd91 + 32'd7);
    endfunction

    function automatic logic [63:0] dut_word(input int inst, input logic [31:0] base, input int nb);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < nb; i++) begin
            if (dut_mem.exists(key(inst, base + 32'(i))))
                w[8*i +: 8] = dut_mem[key(inst, base + 32'(i))];
            else
                w[8*i +: 8] = init_byte(inst, base + 32'(i));
        end
        return w;
    endfunction

    function automatic logic [63:0] ref_word(input int inst, input logic [31:0] base, input int nb);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < nb; i++) begin
            if (ref_mem.exists(key(inst, base + 32'(i))))
                w[8*i +: 8] = ref_mem[key(inst, base + 32'(i))];
            else
                w[8*i +: 8] = init_byte(inst, base + 32'(i));
        end
        return w;
    endfunction

    task automatic preload(input int inst, input logic [31:0] base, input logic [63:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            dut_mem[key(inst, base + 32'(i))] = w[8*i +: 8];
            ref_mem[key(inst, base + 32'(i))] = w[8*i +: 8];
        end
    endtask

    // Read pipelines: data fetched at the read-strobe edge appears LAT cycles later.
    logic        pa_v;
    logic [31:0] pa_d;
    logic        pb_v [3];
    logic [63:0] pb_d [3];
    logic [63:0] junk;

    initial begin
        pa_v = 1'b0;
        pa_d = '0;
        junk = '0;
        for (int i = 0; i < 3; i++) begin
            pb_v[i] = 1'b0;
            pb_d[i] = '0;
        end
    end

    always @(posedge clk) begin
        junk     <= {$urandom, $urandom};
        pa_v     <= ifa.mem_rd_en;
        pa_d     <= 32'(dut_word(0, ifa.mem_addr, 4));
        pb_v[0]  <= ifb.mem_rd_en;
        pb_d[0]  <= dut_word(1, ifb.mem_addr, 8);
        pb_v[1]  <= pb_v[0];
        pb_d[1]  <= pb_d[0];
        pb_v[2]  <= pb_v[1];
        pb_d[2]  <= pb_d[1];
    end

    // Memory writes from each DUT.
    always @(posedge clk) begin
        if (ifa.mem_we)
            for (int k = 0; k < 4; k++)
                dut_mem[key(0, ifa.mem_addr + 32'(k))] = ifa.mem_wdata[8*k +: 8];
        if (ifb.mem_we)
            for (int k = 0; k < 8; k++)
                dut_mem[key(1, ifb.mem_addr + 32'(k))] = ifb.mem_wdata[8*k +: 8];
    end

    assign ifa.mem_rdata = pa_v ? pa_d : junk[31:0];
    assign ifb.mem_rdata = pb_v[2] ? pb_d[2] : junk;

    // ---------------- observation / drive ----------------
    typedef struct {
        logic        ready;
        logic        rd_en;
        logic        we;
        logic        done;
        logic        err;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } obs_t;

    function automatic obs_t sample(input int inst);
        obs_t o;
        if (inst == 0) begin
            o.ready = ifa.req_ready;  o.rd_en = ifa.mem_rd_en; o.we = ifa.mem_we;
            o.done  = ifa.store_done; o.err   = ifa.align_err; o.addr = ifa.mem_addr;
            o.wdata = {32'b0, ifa.mem_wdata}; o.be = {4'b0, ifa.mem_be};
        end else begin
            o.ready = ifb.req_ready;  o.rd_en = ifb.mem_rd_en; o.we = ifb.mem_we;
            o.done  = ifb.store_done; o.err   = ifb.align_err; o.addr = ifb.mem_addr;
            o.wdata = ifb.mem_wdata;  o.be = ifb.mem_be;
        end
        return o;
    endfunction

    task automatic drive(input int inst, input logic v, input logic [31:0] a,
                         input logic [63:0] d, input logic [1:0] s);
        if (inst == 0) begin
            ifa.req_valid = v; ifa.req_addr = a; ifa.req_data = d[31:0]; ifa.req_size = s;
        end else begin
            ifb.req_valid = v; ifb.req_addr = a; ifb.req_data = d; ifb.req_size = s;
        end
    endtask

    task automatic check_reset(input int inst, input string tag);
        obs_t o;
        o = sample(inst);
        check({tag, "_ready"}, 64'(o.ready), 64'd1);
        check({tag, "_rd_en"}, 64'(o.rd_en), 64'd0);
        check({tag, "_we"},    64'(o.we),    64'd0);
        check({tag, "_done"},  64'(o.done),  64'd0);
        check({tag, "_err"},   64'(o.err),   64'd0);
        check({tag, "_addr"},  64'(o.addr),  64'd0);
        check({tag, "_wdata"}, o.wdata,      64'd0);
        check({tag, "_be"},    64'(o.be),    64'd0);
    endtask

    // One store from presentation to the first idle cycle afterwards.
    // preset: the request is already on the bus and will be taken at the next edge.
    // nxt: keep req_valid high with the next request while this one is busy.
    task automatic do_store(input int inst, input logic [31:0] a, input logic [63:0] d,
                            input logic [1:0] s, input bit preset, input bit nxt,
                            input logic [31:0] na, input logic [63:0] nd, input logic [1:0] ns,
                            output logic [63:0] wd_out);
        obs_t        o;
        int          nb, lat, off, n, busy_exp, waited;
        bit          legal;
        logic [31:0] base;
        logic [63:0] exp_word, be_exp;
        int          rd_cnt, we_cnt, err_cnt, both, done_mis, busy, rd_k, we_k, err_k;
        logic [31:0] rd_addr, we_addr;
        logic [63:0] we_data;
        logic [7:0]  we_be;

        nb       = (inst == 0) ? 4 : 8;
        lat      = (inst == 0) ? LAT_A : LAT_B;
        off      = int'(a & 32'(nb - 1));
        base     = a & ~32'(nb - 1);
        n        = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : nb;
        legal    = (s != 2'd3) && ((off % n) == 0);
        busy_exp = (!legal || s == 2'd2) ? 1 : lat + 2;
        rd_cnt = 0; we_cnt = 0; err_cnt = 0; both = 0; done_mis = 0; busy = 0;
        rd_k = 0; we_k = 0; err_k = 0; rd_addr = '0; we_addr = '0; we_data = '0; we_be = '0;
        wd_out = '0;

        if (!preset) begin
            waited = 0;
            forever begin
                @(negedge clk);
                o = sample(inst);
                if (o.ready) break;
                waited++;
                if (waited > 100) begin
                    check("ready_wait", 64'(o.ready), 64'd1);
                    return;
                end
            end
            drive(inst, 1'b1, a, d, s);
        end
        @(posedge clk);
        @(negedge clk);
        if (nxt) drive(inst, 1'b1, na, nd, ns);
        else     drive(inst, 1'b0, '0, '0, 2'd0);

        for (int k = 1; k <= busy_exp + 1; k++) begin
            if (k > 1) @(negedge clk);
            o = sample(inst);
            if (o.rd_en) begin rd_cnt++; rd_k = k; rd_addr = o.addr; end
            if (o.we) begin we_cnt++; we_k = k; we_addr = o.addr; we_data = o.wdata; we_be = o.be; end
            if (o.err) begin err_cnt++; err_k = k; end
            if (o.rd_en && o.we) both++;
            if (o.done != o.we) done_mis++;
            if (!o.ready) busy++;
        end

        // Reference update: the legal store replaces n bytes starting at its address.
        if (legal)
            for (int i = 0; i < n; i++)
                ref_mem[key(inst, a + 32'(i))] = d[8*i +: 8];
        exp_word = ref_word(inst, base, nb);
        be_exp   = ((64'd1 << n) - 64'd1) << off;

        check("busy_cycles", 64'(busy), 64'(busy_exp));
        check("rd_we_overlap", 64'(both), 64'd0);
        check("done_vs_we", 64'(done_mis), 64'd0);
        if (!legal) begin
            check("err_cycle", 64'(err_k), 64'd1);
            check("err_count", 64'(err_cnt), 64'd1);
            check("err_rd_count", 64'(rd_cnt), 64'd0);
            check("err_we_count", 64'(we_cnt), 64'd0);
        end else begin
            check("err_count", 64'(err_cnt), 64'd0);
            check("we_count", 64'(we_cnt), 64'd1);
            check("we_cycle", 64'(we_k), (s == 2'd2) ? 64'd1 : 64'(lat + 2));
            check("rd_count", 64'(rd_cnt), (s == 2'd2) ? 64'd0 : 64'd1);
            if (s != 2'd2) begin
                check("rd_cycle", 64'(rd_k), 64'd1);
                check("rd_addr", 64'(rd_addr), 64'(base));
            end
            check("wr_addr", 64'(we_addr), 64'(base));
            check("wr_data", we_data, exp_word);
            check("wr_be", 64'(we_be), be_exp);
        end
        wd_out = we_data;
        $display("[TB] inst=%0d addr=%h size=%0d data=%h legal=%0d wdata=%h be=%h",
                 inst, a, s, d, legal, we_data, we_be);
    endtask

    task automatic st(input int inst, input logic [31:0] a, input logic [63:0] d,
                      input logic [1:0] s, output logic [63:0] wd);
        do_store(inst, a, d, s, 1'b0, 1'b0, '0, '0, 2'd0, wd);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] wd;
        logic [31:0] ra;
        logic [1:0]  rs;
        int          inst, nbr, we_seen;

        drive(0, 1'b0, '0, '0, 2'd0);
        drive(1, 1'b0, '0, '0, 2'd0);
        repeat (3) @(negedge clk);
        check_reset(0, "rst_a");
        check_reset(1, "rst_b");
        rst = 1'b0;

        // Directed cases on the 32-bit, latency-1 instance.
        preload(0, 32'h1000, 64'h11223344, 4);
        st(0, 32'h1002, 64'h000000AB, 2'd0, wd);
        check("tp_byte", wd, 64'h11AB3344);
        preload(0, 32'h1000, 64'h11223344, 4);
        st(0, 32'h1002, 64'h0000BEEF, 2'd1, wd);
        check("tp_half_hi", wd, 64'hBEEF3344);
        preload(0, 32'h1000, 64'h11223344, 4);
        st(0, 32'h1000, 64'h0000BEEF, 2'd1, wd);
        check("tp_half_lo", wd, 64'h1122BEEF);
        st(0, 32'h1004, 64'hDEADBEEF, 2'd2, wd);
        check("tp_word", wd, 64'hDEADBEEF);
        st(0, 32'h1001, 64'h1234, 2'd1, wd);
        st(0, 32'h1006, 64'h12345678, 2'd2, wd);
        st(0, 32'h1000, 64'h55, 2'd3, wd);

        // 64-bit, latency-3 instance: byte at lane 5.
        preload(1, 32'h3000, 64'h0807060504030201, 8);
        st(1, 32'h3005, 64'hFFFFFFFF_FFFFFF5C, 2'd0, wd);
        check("tp_lane5", wd, 64'h08075C0504030201);
        st(1, 32'h3006, 64'hA5A5_0000_0000_C3D2, 2'd1, wd);
        st(1, 32'h3003, 64'h9999, 2'd1, wd);

        // Back-to-back: the second request waits on the bus until IDLE.
        do_store(0, 32'h1101, 64'hFFFF_FF77, 2'd0, 1'b0, 1'b1, 32'h1102, 64'h1234, 2'd1, wd);
        do_store(0, 32'h1102, 64'h1234, 2'd1, 1'b1, 1'b0, '0, '0, 2'd0, wd);
        do_store(1, 32'h3008, 64'h0123456789ABCDEF, 2'd2, 1'b0, 1'b1, 32'h300B, 64'h42, 2'd0, wd);
        do_store(1, 32'h300B, 64'h42, 2'd0, 1'b1, 1'b0, '0, '0, 2'd0, wd);

        // Reset while the 64-bit instance is in its wait phase.
        @(negedge clk);
        drive(1, 1'b1, 32'h3011, 64'hEE, 2'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, '0, '0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset(1, "midrst_b");
        we_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ifb.mem_we) we_seen++;
        end
        check("midrst_no_we", 64'(we_seen), 64'd0);
        rst = 1'b0;
        we_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ifb.mem_we) we_seen++;
        end
        check("postrst_no_we", 64'(we_seen), 64'd0);
        st(1, 32'h3012, 64'hC0DE, 2'd1, wd);
        st(1, 32'h3011, 64'h3C, 2'd0, wd);

        // Randomised traffic on both instances.
        for (int i = 0; i < 80; i++) begin
            inst = i % 2;
            nbr  = (inst == 0) ? 4 : 8;
            rs   = 2'($urandom_range(0, 3));
            ra   = ((inst == 0) ? 32'h2000 : 32'h4000) + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                if (rs == 2'd1) ra = ra & ~32'd1;
                else if (rs == 2'd2) ra = ra & ~32'(nbr - 1);
            end
            st(inst, ra, {$urandom, $urandom}, rs, wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
Parametrised successor to the sb/sw write-data select in the MEM stage. It accepts byte, halfword and word store requests and forms the memory write itself. Full-word stores are written directly. Sub-word stores use a read-modify-write over a word-wide data memory port with configurable read latency. The pipeline stalls on req_ready low while a store is in flight.

Parameters:
DATA_W, 32, memory word width in bits; power-of-two multiple of 8, at least 16.
ADDR_W, 32, byte-address width.
MEM_LAT, 1, data-memory read latency in cycles (at least 1).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  store request present.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_addr  input  ADDR_W  byte address of the store.
req_data  input  DATA_W  store data, right-justified (byte in [7:0], half in [15:0]).
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
mem_rd_en  output  1  read strobe to data memory.
mem_addr  output  ADDR_W  word-aligned address (low log2(DATA_W/8) bits zero).
mem_rdata  input  DATA_W  read data, valid MEM_LAT cycles after the mem_rd_en cycle.
mem_we  output  1  write strobe.
mem_wdata  output  DATA_W  merged full word to write.
mem_be  output  DATA_W/8  byte lanes modified by this store (informational; full word always written).
store_done  output  1  one-cycle pulse in the cycle mem_we is high.
align_err  output  1  one-cycle pulse for a rejected request.

Behaviour:
- Reset (async): state IDLE; req_ready=1; mem_rd_en, mem_we, store_done, align_err = 0; mem_addr, mem_wdata, mem_be = 0; captured request registers cleared.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. The address, data and size are captured at that edge. Inputs are ignored outside IDLE. A requester holding req_valid is accepted on the first IDLE cycle.
- Byte offset: off = req_addr[log2(DATA_W/8)-1:0]. Lanes are little-endian (lane k = bits [8k+7:8k]).
- Legality: a byte is always legal. A half needs off[0]=0. A word needs off=0. size 3 is illegal.
- State machine (all outputs are registered or decoded from state):
  - IDLE: req_ready=1. On accept, go to ERR if illegal, WR if word, RD if byte or half.
  - RD (1 cycle): mem_rd_en=1, mem_addr=aligned address. Next state WT, with wait counter loaded to MEM_LAT-1.
  - WT (MEM_LAT cycles): counter decrements each cycle. At the edge ending the cycle with counter=0, capture mem_rdata. Replace lanes off (byte) or off, off+1 (half) with req_data. Go to WR.
  - WR (1 cycle): mem_we=1, store_done=1, mem_addr=aligned address, mem_wdata=merged word, or req_data for a word store. mem_be is 1 bit for a byte, 2 bits for a half, all ones for a word. Next state IDLE.
  - ERR (1 cycle): align_err=1, no memory strobes. Next state IDLE.
- Latency from accept to mem_we: word 1 cycle; byte/half MEM_LAT+2 cycles. Occupancy per store: word 2 cycles; byte/half MEM_LAT+3 cycles, IDLE cycle included.
- mem_rd_en and mem_we are never high in the same cycle. At most one write per accepted request.
- Reset mid-operation (any state): return to IDLE immediately and drop the in-flight store. mem_we must not assert for it.
- mem_wdata and mem_be hold their last values outside WR.

Test Plan:
- Byte store, DATA_W=32, MEM_LAT=1: addr 0x1002, data 0x000000AB, mem_rdata 0x11223344 → RD 1 cycle, WT 1 cycle, then WR with mem_addr 0x1000, mem_wdata 0x11AB3344, mem_be 0100, store_done=1.
- Half store: addr 0x1002, data 0x0000BEEF, old word 0x11223344 → mem_wdata 0xBEEF3344, mem_be 1100. Repeat at offset 0 → 0x1122BEEF, mem_be 0011.
- Word store: addr 0x1004, data 0xDEADBEEF → no mem_rd_en; mem_we one cycle after accept with 0x00001004 / 0xDEADBEEF, mem_be 1111; req_ready back to 1 the next cycle.
- Illegal requests: half at 0x1001, word at 0x1006, size 3 → align_err pulse one cycle after accept each time; mem_rd_en and mem_we stay 0 throughout.
- MEM_LAT=3 and DATA_W=64: byte at offset 5 → mem_we exactly 5 cycles after accept; only lane 5 changed; req_ready low for 5 cycles.
- Back-to-back and reset: hold req_valid with two queued stores → the second is accepted only on the IDLE cycle. Assert reset during WT → all outputs at reset values immediately, no mem_we, a new store completes normally after release.
